// File: rtl/sal_ddr_cmd_decoder.sv
// DFI control-bus receiver: decodes DDR2 commands, tracks bank state, checks timing.
// Optional: define SAL_CMD_DEC_ERR_CNT_EN to add the saturating err_cnt output.
module sal_ddr_cmd_decoder #(
  parameter  int NUM_BANKS = 8,
  parameter  int ADDR_W    = 16,
  parameter  int T_W       = 8,
  localparam int BA_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
  input  logic [BA_W-1:0]      ba,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [T_W-1:0]       t_rcd_m1,
  input  logic [T_W-1:0]       t_rp_m1,
  input  logic [T_W-1:0]       t_ras_m1,
  input  logic [T_W-1:0]       t_rfc_m1,
  input  logic [T_W-1:0]       t_rtp_m1,
  input  logic [T_W-1:0]       t_wtp_m1,
  input  logic [T_W-1:0]       t_rrd_m1,
  input  logic [T_W-1:0]       t_ccd_m1,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_code,
  output logic [BA_W-1:0]      cmd_ba,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [ADDR_W-1:0]    open_row,
  output logic                 err,
  output logic [3:0]           err_code
`ifdef SAL_CMD_DEC_ERR_CNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5,
    CMD_MRS = 3'd6
  } cmd_e;

  cmd_e              dec_cmd, s1_cmd;
  logic [BA_W-1:0]   s1_ba;
  logic [ADDR_W-1:0] s1_addr;

  logic [T_W-1:0]    rcd_q [NUM_BANKS];
  logic [T_W-1:0]    ras_q [NUM_BANKS];
  logic [T_W-1:0]    rp_q  [NUM_BANKS];
  logic [T_W-1:0]    rtp_q [NUM_BANKS];
  logic [T_W-1:0]    wtp_q [NUM_BANKS];
  logic [ADDR_W-1:0] row_q [NUM_BANKS];
  logic [T_W-1:0]    rrd_q, ccd_q, rfc_q;

  logic [NUM_BANKS-1:0] ba_hot, pre_mask, pre_busy;
  logic                 is_act, is_rd, is_wr, is_rdwr, is_pre, is_ref, is_mrs, any_open;
  logic [3:0]           chk_code;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] v);
    return (v == '0) ? v : v - T_W'(1);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_cmd = CMD_NOP;
    // An X/Z chip select compares false here and falls through to NOP.
    if (cke && (cs_n == 1'b0)) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  dec_cmd = CMD_ACT;
        3'b101:  dec_cmd = CMD_RD;
        3'b100:  dec_cmd = CMD_WR;
        3'b010:  dec_cmd = CMD_PRE;
        3'b001:  dec_cmd = CMD_REF;
        3'b000:  dec_cmd = CMD_MRS;
        default: dec_cmd = CMD_NOP;
      endcase
    end
  end

  // Capture stage: checks and state updates happen one edge after sampling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_cmd  <= CMD_NOP;
      s1_ba   <= '0;
      s1_addr <= '0;
    end else begin
      s1_cmd  <= dec_cmd;
      s1_ba   <= ba;
      s1_addr <= addr;
    end
  end

  assign is_act   = (s1_cmd == CMD_ACT);
  assign is_rd    = (s1_cmd == CMD_RD);
  assign is_wr    = (s1_cmd == CMD_WR);
  assign is_rdwr  = is_rd || is_wr;
  assign is_pre   = (s1_cmd == CMD_PRE);
  assign is_ref   = (s1_cmd == CMD_REF);
  assign is_mrs   = (s1_cmd == CMD_MRS);
  assign any_open = |bank_open;

  always_comb begin
    ba_hot         = '0;
    ba_hot[s1_ba]  = 1'b1;
    pre_mask       = s1_addr[10] ? '1 : ba_hot;
    pre_busy       = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      pre_busy[i] = pre_mask[i] && bank_open[i] &&
                    ((ras_q[i] != '0) || (rtp_q[i] != '0) || (wtp_q[i] != '0));
    end
  end

  // Priority chain: the lowest-numbered violation is reported.
  always_comb begin
    chk_code = 4'd0;
    if      (is_act  && bank_open[s1_ba])               chk_code = 4'd1;
    else if (is_rdwr && !bank_open[s1_ba])              chk_code = 4'd2;
    else if (is_act  && (rp_q[s1_ba] != '0))            chk_code = 4'd3;
    else if (is_act  && (rrd_q != '0))                  chk_code = 4'd4;
    else if (is_rdwr && (rcd_q[s1_ba] != '0))           chk_code = 4'd5;
    else if (is_rdwr && (ccd_q != '0))                  chk_code = 4'd6;
    else if (is_pre  && (pre_busy != '0))               chk_code = 4'd7;
    else if (is_ref  && any_open)                       chk_code = 4'd8;
    else if ((s1_cmd != CMD_NOP) && (rfc_q != '0))      chk_code = 4'd9;
    else if (is_mrs  && any_open)                       chk_code = 4'd10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NOP;
      cmd_ba    <= '0;
      cmd_addr  <= '0;
      err       <= 1'b0;
      err_code  <= 4'd0;
      bank_open <= '0;
      rrd_q     <= '0;
      ccd_q     <= '0;
      rfc_q     <= '0;
      // NOTE: the row table is small and reset so open_row is defined from the first cycle.
      for (int i = 0; i < NUM_BANKS; i++) begin
        rcd_q[i] <= '0;
        ras_q[i] <= '0;
        rp_q[i]  <= '0;
        rtp_q[i] <= '0;
        wtp_q[i] <= '0;
        row_q[i] <= '0;
      end
    end else begin
      cmd_valid <= (s1_cmd != CMD_NOP);
      cmd_code  <= s1_cmd;
      if (s1_cmd != CMD_NOP) begin
        cmd_ba   <= s1_ba;
        cmd_addr <= s1_addr;
      end
      err      <= (chk_code != 4'd0);
      err_code <= chk_code;
      rrd_q    <= is_act  ? t_rrd_m1 : sat_dec(rrd_q);
      ccd_q    <= is_rdwr ? t_ccd_m1 : sat_dec(ccd_q);
      rfc_q    <= is_ref  ? t_rfc_m1 : sat_dec(rfc_q);
      for (int i = 0; i < NUM_BANKS; i++) begin
        rcd_q[i] <= (is_act && ba_hot[i]) ? t_rcd_m1 : sat_dec(rcd_q[i]);
        ras_q[i] <= (is_act && ba_hot[i]) ? t_ras_m1 : sat_dec(ras_q[i]);
        rtp_q[i] <= (is_rd  && ba_hot[i]) ? t_rtp_m1 : sat_dec(rtp_q[i]);
        wtp_q[i] <= (is_wr  && ba_hot[i]) ? t_wtp_m1 : sat_dec(wtp_q[i]);
        // Precharge of an already-closed bank leaves tRP untouched.
        rp_q[i]  <= (is_pre && pre_mask[i] && bank_open[i]) ? t_rp_m1 : sat_dec(rp_q[i]);
        if (is_act && ba_hot[i]) begin
          bank_open[i] <= 1'b1;
          row_q[i]     <= s1_addr;
        end else if (is_pre && pre_mask[i]) begin
          bank_open[i] <= 1'b0;
        end
      end
    end
  end

  assign open_row = bank_open[cmd_ba] ? row_q[cmd_ba] : '0;

`ifdef SAL_CMD_DEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((chk_code != 4'd0) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sal_ddr_cmd_decoder.sv
// Self-checking bench for sal_ddr_cmd_decoder: directed protocol scenarios plus
// randomized traffic against a timestamp-based reference model.
module tb_sal_ddr_cmd_decoder;

  localparam int NB    = 8;
  localparam int NEVER = -100000;
  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                         C_PRE = 3'd4, C_REF = 3'd5, C_MRS = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [15:0] addr;
  logic [7:0]  t_rcd_m1, t_rp_m1, t_ras_m1, t_rfc_m1, t_rtp_m1, t_wtp_m1, t_rrd_m1, t_ccd_m1;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_ba;
  logic [15:0] cmd_addr;
  logic [7:0]  bank_open;
  logic [15:0] open_row;
  logic        err;
  logic [3:0]  err_code;
`ifdef SAL_CMD_DEC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  sal_ddr_cmd_decoder #(.NUM_BANKS(8), .ADDR_W(16), .T_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr),
    .t_rcd_m1(t_rcd_m1), .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1), .t_rfc_m1(t_rfc_m1),
    .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1), .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .bank_open(bank_open), .open_row(open_row), .err(err), .err_code(err_code)
`ifdef SAL_CMD_DEC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [2:0]  code;
    logic [2:0]  ba;
    logic [15:0] addr;
    logic [3:0]  ecode;
    logic [7:0]  open;
    logic        row_chk;
    logic [15:0] row;
    logic [15:0] ecnt;
  } exp_t;

  // Reference model: per-bank and global timestamps of the last triggering command.
  int          cyc;
  bit          m_open [NB];
  logic [15:0] m_row  [NB];
  int          last_act [NB], last_pre [NB], last_rd [NB], last_wr [NB];
  int          last_act_any, last_col, last_ref, m_last_ba, m_ecnt;
  exp_t        exp_prev;
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic bit recent(input int last, input logic [7:0] t);
    return (cyc - last) <= int'(t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0; m_row[i] = 16'h0;
      last_act[i] = NEVER; last_pre[i] = NEVER; last_rd[i] = NEVER; last_wr[i] = NEVER;
    end
    last_act_any = NEVER; last_col = NEVER; last_ref = NEVER;
    m_last_ba = 0; m_ecnt = 0;
    exp_prev = '0;
  endtask

  task automatic model_cmd(input logic [2:0] c, input int b, input logic [15:0] a, output exp_t e);
    int code;
    bit any_open, rdwr, pre_busy;
    any_open = 1'b0;
    pre_busy = 1'b0;
    rdwr = (c == C_RD) || (c == C_WR);
    for (int i = 0; i < NB; i++) begin
      any_open |= m_open[i];
      if (c == C_PRE && (a[10] || i == b) && m_open[i] &&
          (recent(last_act[i], t_ras_m1) || recent(last_rd[i], t_rtp_m1) ||
           recent(last_wr[i], t_wtp_m1)))
        pre_busy = 1'b1;
    end
    code = 0;
    if      (c == C_ACT && m_open[b])                   code = 1;
    else if (rdwr && !m_open[b])                        code = 2;
    else if (c == C_ACT && recent(last_pre[b], t_rp_m1)) code = 3;
    else if (c == C_ACT && recent(last_act_any, t_rrd_m1)) code = 4;
    else if (rdwr && recent(last_act[b], t_rcd_m1))     code = 5;
    else if (rdwr && recent(last_col, t_ccd_m1))        code = 6;
    else if (c == C_PRE && pre_busy)                    code = 7;
    else if (c == C_REF && any_open)                    code = 8;
    else if (c != C_NOP && recent(last_ref, t_rfc_m1))  code = 9;
    else if (c == C_MRS && any_open)                    code = 10;
    case (c)
      C_ACT: begin m_open[b] = 1'b1; m_row[b] = a; last_act[b] = cyc; last_act_any = cyc; end
      C_RD:  begin last_rd[b] = cyc; last_col = cyc; end
      C_WR:  begin last_wr[b] = cyc; last_col = cyc; end
      C_PRE: for (int i = 0; i < NB; i++)
               if ((a[10] || i == b) && m_open[i]) begin m_open[i] = 1'b0; last_pre[i] = cyc; end
      C_REF: last_ref = cyc;
      default: ;
    endcase
    if (code != 0 && m_ecnt < 65535) m_ecnt++;
    if (c != C_NOP) m_last_ba = b;
    e.valid = (c != C_NOP);
    e.code  = c;
    e.ba    = 3'(b);
    e.addr  = a;
    e.ecode = 4'(code);
    for (int i = 0; i < NB; i++) e.open[i] = m_open[i];
    e.row_chk = m_open[m_last_ba];
    e.row     = m_row[m_last_ba];
    e.ecnt    = 16'(m_ecnt);
  endtask

  task automatic drive(input logic [2:0] c, input int b, input logic [15:0] a);
    logic [2:0] pins;
    cke = 1'b1; cs_n = 1'b0; ba = 3'(b); addr = a;
    case (c)
      C_ACT: pins = 3'b011;
      C_RD:  pins = 3'b101;
      C_WR:  pins = 3'b100;
      C_PRE: pins = 3'b010;
      C_REF: pins = 3'b001;
      C_MRS: pins = 3'b000;
      default: begin
        pins = 3'($urandom);
        case ($urandom_range(0, 2))
          0:       pins = 3'b111;
          1:       cs_n = 1'b1;
          default: cke  = 1'b0;
        endcase
      end
    endcase
    {ras_n, cas_n, we_n} = pins;
  endtask

  // One bus cycle: drive a command, then check the outputs of the previous one.
  task automatic step(input logic [2:0] c, input int b, input logic [15:0] a);
    exp_t e;
    @(negedge clk);
    drive(c, b, a);
    model_cmd(c, b, a, e);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({cmd_valid, cmd_code, err, err_code} !==
        {exp_prev.valid, exp_prev.code, exp_prev.ecode != 4'd0, exp_prev.ecode}) begin
      n_fail++;
      $display("FAIL cmd cyc=%0d got v=%0b code=%0d err=%0b ec=%0d want v=%0b code=%0d ec=%0d",
               cyc, cmd_valid, cmd_code, err, err_code, exp_prev.valid, exp_prev.code, exp_prev.ecode);
    end
    n_cmp++;
    if (bank_open !== exp_prev.open) begin
      n_fail++;
      $display("FAIL bank_open cyc=%0d got=%b want=%b", cyc, bank_open, exp_prev.open);
    end
    if (exp_prev.valid) begin
      n_cmp++;
      if ({cmd_ba, cmd_addr} !== {exp_prev.ba, exp_prev.addr}) begin
        n_fail++;
        $display("FAIL cmd_ba_addr cyc=%0d got=%0d/%h want=%0d/%h",
                 cyc, cmd_ba, cmd_addr, exp_prev.ba, exp_prev.addr);
      end
    end
    if (exp_prev.row_chk) begin
      n_cmp++;
      if (open_row !== exp_prev.row) begin
        n_fail++;
        $display("FAIL open_row cyc=%0d got=%h want=%h", cyc, open_row, exp_prev.row);
      end
    end
`ifdef SAL_CMD_DEC_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== exp_prev.ecnt) begin
      n_fail++;
      $display("FAIL err_cnt cyc=%0d got=%0d want=%0d", cyc, err_cnt, exp_prev.ecnt);
    end
`endif
    exp_prev = e;
    cyc++;
  endtask

  // Hold reset for one edge while a random command sits on the bus; it must be dropped.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'($urandom_range(1, 6)), $urandom_range(0, 7), 16'($urandom));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({cmd_valid, cmd_code, cmd_ba, cmd_addr, bank_open, open_row, err, err_code} !== '0) begin
      n_fail++;
      $display("FAIL %s got v=%0b code=%0d ba=%0d addr=%h open=%b row=%h err=%0b ec=%0d want all 0",
               tag, cmd_valid, cmd_code, cmd_ba, cmd_addr, bank_open, open_row, err, err_code);
    end
`ifdef SAL_CMD_DEC_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL %s err_cnt got=%0d want=0", tag, err_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset_state");
  endtask

  task automatic test_act_rd();
    do_reset();
    step(C_ACT, 2, 16'h01A5);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if ({cmd_code, bank_open[2], open_row} !== {C_ACT, 1'b1, 16'h01A5}) begin
      n_fail++;
      $display("FAIL act_b2 got code=%0d open2=%0b row=%h want 1/1/01a5", cmd_code, bank_open[2], open_row);
    end
    step(C_NOP, 0, 16'h0);
    step(C_NOP, 0, 16'h0);
    step(C_RD, 2, 16'h0010);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if ({cmd_code, err} !== {C_RD, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_trcd_ok got code=%0d err=%0b want 2/0", cmd_code, err);
    end
    do_reset();
    step(C_ACT, 2, 16'h01A5);
    step(C_NOP, 0, 16'h0);
    step(C_NOP, 0, 16'h0);
    step(C_RD, 2, 16'h0010);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if ({err, err_code, bank_open[2]} !== {1'b1, 4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_trcd_early got err=%0b ec=%0d open2=%0b want 1/5/1", err, err_code, bank_open[2]);
    end
  endtask

  task automatic test_rrd();
    do_reset();
    step(C_ACT, 0, 16'h0011);
    step(C_ACT, 1, 16'h0022);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if (err_code !== 4'd4) begin
      n_fail++;
      $display("FAIL rrd_early got ec=%0d want 4", err_code);
    end
    do_reset();
    step(C_ACT, 0, 16'h0011);
    step(C_NOP, 0, 16'h0);
    step(C_ACT, 1, 16'h0022);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if ({err, bank_open} !== {1'b0, 8'b0000_0011}) begin
      n_fail++;
      $display("FAIL rrd_ok got err=%0b open=%b want 0/00000011", err, bank_open);
    end
  endtask

  // ACT b0 @0, ACT b3 @2, PRE-all @8 (tRAS met for both banks).
  task automatic open_b0_b3_pre_all();
    do_reset();
    step(C_ACT, 0, 16'h0100);
    step(C_NOP, 0, 16'h0);
    step(C_ACT, 3, 16'h0300);
    for (int i = 0; i < 5; i++) step(C_NOP, 0, 16'h0);
    step(C_PRE, 0, 16'h0400);
    step(C_NOP, 0, 16'h0);
  endtask

  task automatic test_pre_all();
    open_b0_b3_pre_all();
    n_cmp++;
    if ({err, cmd_code, bank_open} !== {1'b0, C_PRE, 8'h00}) begin
      n_fail++;
      $display("FAIL pre_all got err=%0b code=%0d open=%b want 0/4/00000000", err, cmd_code, bank_open);
    end
    step(C_ACT, 0, 16'h0100);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if (err_code !== 4'd3) begin
      n_fail++;
      $display("FAIL trp_early got ec=%0d want 3", err_code);
    end
    open_b0_b3_pre_all();
    step(C_NOP, 0, 16'h0);
    step(C_ACT, 0, 16'h0100);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL trp_ok got err=%0b want 0", err);
    end
  endtask

  task automatic test_refresh();
    do_reset();
    step(C_REF, 0, 16'h0);
    for (int i = 0; i < 8; i++) step(C_NOP, 0, 16'h0);
    step(C_ACT, 0, 16'h0055);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if (err_code !== 4'd9) begin
      n_fail++;
      $display("FAIL trfc_early got ec=%0d want 9", err_code);
    end
    do_reset();
    step(C_REF, 0, 16'h0);
    for (int i = 0; i < 9; i++) step(C_NOP, 0, 16'h0);
    step(C_ACT, 0, 16'h0055);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if ({err, cmd_code} !== {1'b0, C_ACT}) begin
      n_fail++;
      $display("FAIL trfc_ok got err=%0b code=%0d want 0/1", err, cmd_code);
    end
    do_reset();
    step(C_ACT, 5, 16'h0555);
    step(C_NOP, 0, 16'h0);
    step(C_REF, 0, 16'h0);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if (err_code !== 4'd8) begin
      n_fail++;
      $display("FAIL ref_open got ec=%0d want 8", err_code);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    step(C_ACT, 1, 16'h0777);
    step(C_RD, 1, 16'h0008);
    do_reset();
    check_all_zero("midrun_reset");
    step(C_RD, 1, 16'h0020);
    step(C_NOP, 0, 16'h0);
    n_cmp++;
    if ({err, err_code} !== {1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL rd_after_reset got err=%0b ec=%0d want 1/2", err, err_code);
    end
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [15:0] a;
    int          r;
    rst_n    = 1'b0;
    t_rcd_m1 = 8'($urandom_range(0, 5));
    t_rp_m1  = 8'($urandom_range(0, 5));
    t_ras_m1 = 8'($urandom_range(0, 8));
    t_rfc_m1 = 8'($urandom_range(0, 12));
    t_rtp_m1 = 8'($urandom_range(0, 4));
    t_wtp_m1 = 8'($urandom_range(0, 6));
    t_rrd_m1 = 8'($urandom_range(0, 3));
    t_ccd_m1 = 8'($urandom_range(0, 3));
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 30) c = C_NOP;
      else if (r < 50) c = C_ACT;
      else if (r < 65) c = C_RD;
      else if (r < 80) c = C_WR;
      else if (r < 95) c = C_PRE;
      else if (r < 98) c = C_REF;
      else             c = C_MRS;
      a = 16'($urandom);
      a[10] = ($urandom_range(0, 3) == 0);
      step(c, $urandom_range(0, 7), a);
    end
    step(C_NOP, 0, 16'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    cke = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = 3'd0; addr = 16'h0;
    t_rcd_m1 = 8'd3; t_rp_m1 = 8'd2; t_ras_m1 = 8'd5; t_rfc_m1 = 8'd9;
    t_rtp_m1 = 8'd2; t_wtp_m1 = 8'd3; t_rrd_m1 = 8'd1; t_ccd_m1 = 8'd1;
    cyc = 0;
    model_reset();
    test_reset();
    test_act_rd();
    test_rrd();
    test_pre_all();
    test_refresh();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
